// File: rtl/obi_ctx_arb_pkg.sv
// Shared types for the core / context-engine OBI data-port arbiter.
package obi_ctx_arb_pkg;

    typedef enum logic {
        SRC_CORE = 1'b0,
        SRC_CTX  = 1'b1
    } arb_src_e;

    typedef struct packed {
        arb_src_e src;
        logic     we;
    } track_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HOLD_CORE = 2'd1,
        ST_HOLD_CTX  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/obi_ctx_track_fifo.sv
// In-order FIFO recording the issuing master and direction of each accepted bus transaction.
module obi_ctx_track_fifo
    import obi_ctx_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  track_entry_t    push_data_i,
    input  logic            pop_i,
    output track_entry_t    head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    track_entry_t    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/obi_ctx_arbiter.sv
// Shares the data-memory OBI bus between the core LSU and the context engine, routing responses in order.
// Optional starvation guard for the context engine: define CTX_ARB_STARVE_GUARD_EN.
module obi_ctx_arbiter
    import obi_ctx_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned MAX_CORE_BURST  = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 core_req_i,
    input  logic                                 core_we_i,
    input  logic [3:0]                           core_be_i,
    input  logic [31:0]                          core_addr_i,
    input  logic [31:0]                          core_wdata_i,
    output logic                                 core_gnt_o,
    output logic                                 core_rvalid_o,
    output logic [31:0]                          core_rdata_o,
    input  logic                                 ctx_req_i,
    input  logic                                 ctx_we_i,
    input  logic [31:0]                          ctx_addr_i,
    input  logic [31:0]                          ctx_wdata_i,
    output logic                                 ctx_gnt_o,
    output logic                                 ctx_rvalid_o,
    output logic [31:0]                          ctx_rdata_o,
    output logic                                 bus_req_o,
    output logic                                 bus_we_o,
    output logic [3:0]                           bus_be_o,
    output logic [31:0]                          bus_addr_o,
    output logic [31:0]                          bus_wdata_o,
    input  logic                                 bus_gnt_i,
    input  logic                                 bus_rvalid_i,
    input  logic [31:0]                          bus_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
    output logic                                 orphan_rsp_o
);

    if (MAX_OUTSTANDING < 2 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0 ||
        MAX_CORE_BURST < 1) begin : g_bad_cfg
        $error("obi_ctx_arbiter: MAX_OUTSTANDING must be a power of two >= 2, MAX_CORE_BURST >= 1");
    end

    arb_state_e   state_q;
    arb_state_e   state_d;
    logic         sel_valid;
    arb_src_e     sel_src;
    logic         xfer;
    logic         ctx_first;
    logic         fifo_full;
    logic         fifo_empty;
    logic         pop;
    track_entry_t head;
    track_entry_t push_entry;
    logic         orphan_q;

`ifdef CTX_ARB_STARVE_GUARD_EN
    localparam int unsigned BurstW = $clog2(MAX_CORE_BURST + 1);
    logic [BurstW-1:0] burst_q;

    // Counts core grants taken while ctx was waiting; saturates at the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i || !ctx_req_i || (xfer && sel_src == SRC_CTX)) begin
            burst_q <= '0;
        end else if (xfer && burst_q != BurstW'(MAX_CORE_BURST)) begin
            burst_q <= burst_q + BurstW'(1);
        end
    end

    assign ctx_first = (burst_q == BurstW'(MAX_CORE_BURST));
`else
    assign ctx_first = 1'b0;
`endif

    // Arbitration and next state; the HOLD states freeze the selection until grant.
    always_comb begin
        sel_valid = 1'b0;
        sel_src   = SRC_CORE;
        bus_req_o = 1'b0;
        xfer      = 1'b0;
        state_d   = state_q;
        if (!rst_i) begin
            unique case (state_q)
                ST_HOLD_CORE: begin
                    sel_valid = 1'b1;
                    sel_src   = SRC_CORE;
                    bus_req_o = core_req_i;
                end
                ST_HOLD_CTX: begin
                    sel_valid = 1'b1;
                    sel_src   = SRC_CTX;
                    bus_req_o = ctx_req_i;
                end
                default: begin
                    if (!fifo_full && (core_req_i || ctx_req_i)) begin
                        sel_valid = 1'b1;
                        bus_req_o = 1'b1;
                        sel_src   = (ctx_req_i && (ctx_first || !core_req_i)) ? SRC_CTX : SRC_CORE;
                    end
                end
            endcase
        end
        xfer = bus_req_o & bus_gnt_i;
        if (xfer) begin
            state_d = ST_IDLE;
        end else if (bus_req_o) begin
            state_d = (sel_src == SRC_CTX) ? ST_HOLD_CTX : ST_HOLD_CORE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request field mux; ctx always writes full words.
    always_comb begin
        bus_we_o    = 1'b0;
        bus_be_o    = 4'h0;
        bus_addr_o  = 32'h0;
        bus_wdata_o = 32'h0;
        if (sel_valid) begin
            if (sel_src == SRC_CTX) begin
                bus_we_o    = ctx_we_i;
                bus_be_o    = 4'hF;
                bus_addr_o  = ctx_addr_i;
                bus_wdata_o = ctx_wdata_i;
            end else begin
                bus_we_o    = core_we_i;
                bus_be_o    = core_be_i;
                bus_addr_o  = core_addr_i;
                bus_wdata_o = core_wdata_i;
            end
        end
    end

    assign core_gnt_o = xfer & (sel_src == SRC_CORE);
    assign ctx_gnt_o  = xfer & (sel_src == SRC_CTX);
    assign push_entry = track_entry_t'{src: sel_src, we: bus_we_o};

    obi_ctx_track_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_track_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (xfer),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (outstanding_o)
    );

    // Responses for ctx writes are consumed without signalling either master.
    assign pop           = bus_rvalid_i & ~fifo_empty & ~rst_i;
    assign core_rvalid_o = pop & (head.src == SRC_CORE);
    assign ctx_rvalid_o  = pop & (head.src == SRC_CTX) & ~head.we;
    assign core_rdata_o  = bus_rdata_i;
    assign ctx_rdata_o   = bus_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            orphan_q <= 1'b0;
        end else if (bus_rvalid_i && fifo_empty) begin
            orphan_q <= 1'b1;
        end
    end

    assign orphan_rsp_o = orphan_q;

endmodule

// File: tb/tb_obi_ctx_arbiter.sv
// Self-checking bench for obi_ctx_arbiter: vector table, directed corner sequences, random vs. queue model.
module tb_obi_ctx_arbiter;

    localparam int unsigned MAXO  = 4;
    localparam int unsigned BURST = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_gnt_o, core_rvalid_o;
    logic [31:0] core_rdata_o;
    logic        ctx_req_i, ctx_we_i;
    logic [31:0] ctx_addr_i, ctx_wdata_i;
    logic        ctx_gnt_o, ctx_rvalid_o;
    logic [31:0] ctx_rdata_o;
    logic        bus_req_o, bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic        bus_gnt_i, bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic [2:0]  outstanding_o;
    logic        orphan_rsp_o;

    obi_ctx_arbiter #(.MAX_OUTSTANDING(MAXO), .MAX_CORE_BURST(BURST)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_be_i(core_be_i),
        .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
        .ctx_req_i(ctx_req_i), .ctx_we_i(ctx_we_i), .ctx_addr_i(ctx_addr_i), .ctx_wdata_i(ctx_wdata_i),
        .ctx_gnt_o(ctx_gnt_o), .ctx_rvalid_o(ctx_rvalid_o), .ctx_rdata_o(ctx_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
        .outstanding_o(outstanding_o), .orphan_rsp_o(orphan_rsp_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next();
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        core_req_i = 0; core_we_i = 0; core_be_i = 4'h0; core_addr_i = 0; core_wdata_i = 0;
        ctx_req_i = 0; ctx_we_i = 0; ctx_addr_i = 0; ctx_wdata_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0; bus_rdata_i = 0;
    endtask

    task automatic reset_dut();
        next();
        clear_inputs();
        rst_i = 1;
        next();
        rst_i = 0;
    endtask

    // Single-cycle vectors applied from a freshly reset, empty arbiter.
    typedef struct {
        logic       core_req, core_we;
        logic [3:0] core_be;
        logic       ctx_req, ctx_we, gnt;
        logic       exp_req, exp_we;
        logic [3:0] exp_be;
        logic [31:0] exp_addr;
        logic       exp_cgnt, exp_xgnt;
    } vec_t;

    vec_t vecs [7];

    // Reference model state
    typedef struct packed { logic ctx; logic we; } ent_t;
    ent_t q[$];
    int   lock;         // 0 none, 1 core held, 2 ctx held
    int   burst;
    bit   orphan_m;
    bit   guard_on;

    initial begin
        logic [31:0] exp_wd;
        bit          last_cgnt, last_xgnt;
        int          win;
        bit          req, xfer, pop, starve;
        logic [31:0] exp_addr;

`ifdef CTX_ARB_STARVE_GUARD_EN
        guard_on = 1;
`else
        guard_on = 0;
`endif
        vecs[0] = '{0, 0, 4'h0, 0, 0, 1,  0, 0, 4'h0, 32'h0000_0000, 0, 0};
        vecs[1] = '{1, 0, 4'h3, 0, 0, 1,  1, 0, 4'h3, 32'h1000_0001, 1, 0};
        vecs[2] = '{1, 1, 4'hF, 0, 0, 1,  1, 1, 4'hF, 32'h1000_0002, 1, 0};
        vecs[3] = '{0, 0, 4'h0, 1, 1, 1,  1, 1, 4'hF, 32'h2000_0003, 0, 1};
        vecs[4] = '{0, 0, 4'h0, 1, 0, 0,  1, 0, 4'hF, 32'h2000_0004, 0, 0};
        vecs[5] = '{1, 0, 4'h1, 1, 1, 1,  1, 0, 4'h1, 32'h1000_0005, 1, 0};
        vecs[6] = '{1, 1, 4'h6, 1, 0, 0,  1, 1, 4'h6, 32'h1000_0006, 0, 0};

        clear_inputs();
        rst_i = 1;

        // Outputs suppressed while reset is asserted, even with live requests.
        next();
        core_req_i = 1; ctx_req_i = 1; bus_gnt_i = 1; bus_rvalid_i = 1;
        #1;
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_core_gnt", 32'(core_gnt_o), 32'd0);
        chk("rst_ctx_gnt", 32'(ctx_gnt_o), 32'd0);
        chk("rst_core_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("rst_ctx_rvalid", 32'(ctx_rvalid_o), 32'd0);
        next();
        #1;
        chk("rst_outstanding", 32'(outstanding_o), 32'd0);
        chk("rst_orphan", 32'(orphan_rsp_o), 32'd0);
        clear_inputs();
        next();
        rst_i = 0;

        // Table-driven single-cycle arbitration
        for (int i = 0; i < 7; i++) begin
            reset_dut();
            core_req_i = vecs[i].core_req; core_we_i = vecs[i].core_we; core_be_i = vecs[i].core_be;
            core_addr_i = 32'h1000_0000 + 32'(i); core_wdata_i = ~core_addr_i;
            ctx_req_i = vecs[i].ctx_req; ctx_we_i = vecs[i].ctx_we;
            ctx_addr_i = 32'h2000_0000 + 32'(i); ctx_wdata_i = ~ctx_addr_i;
            bus_gnt_i = vecs[i].gnt;
            #1;
            exp_wd = (vecs[i].exp_addr == 32'h0) ? 32'h0 : ~vecs[i].exp_addr;
            chk($sformatf("vec%0d_req", i), 32'(bus_req_o), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_we", i), 32'(bus_we_o), 32'(vecs[i].exp_we));
            chk($sformatf("vec%0d_be", i), 32'(bus_be_o), 32'(vecs[i].exp_be));
            chk($sformatf("vec%0d_addr", i), bus_addr_o, vecs[i].exp_addr);
            chk($sformatf("vec%0d_wdata", i), bus_wdata_o, exp_wd);
            chk($sformatf("vec%0d_core_gnt", i), 32'(core_gnt_o), 32'(vecs[i].exp_cgnt));
            chk($sformatf("vec%0d_ctx_gnt", i), 32'(ctx_gnt_o), 32'(vecs[i].exp_xgnt));
        end

        // Core read answered one cycle after grant
        reset_dut();
        core_req_i = 1; core_be_i = 4'hF; core_addr_i = 32'h40; bus_gnt_i = 1;
        #1; chk("rd_core_gnt", 32'(core_gnt_o), 32'd1);
        next();
        core_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hDEAD_BEEF;
        #1;
        chk("rd_outstanding1", 32'(outstanding_o), 32'd1);
        chk("rd_core_rvalid", 32'(core_rvalid_o), 32'd1);
        chk("rd_core_rdata", core_rdata_o, 32'hDEAD_BEEF);
        chk("rd_ctx_rvalid", 32'(ctx_rvalid_o), 32'd0);
        next();
        bus_rvalid_i = 0;
        #1; chk("rd_outstanding0", 32'(outstanding_o), 32'd0);

        // ctx write then read of 0x100; write response is swallowed
        next();
        ctx_req_i = 1; ctx_we_i = 1; ctx_addr_i = 32'h100; ctx_wdata_i = 32'h55; bus_gnt_i = 1;
        #1;
        chk("cw_be", 32'(bus_be_o), 32'hF);
        chk("cw_we", 32'(bus_we_o), 32'd1);
        chk("cw_addr", bus_addr_o, 32'h100);
        chk("cw_gnt", 32'(ctx_gnt_o), 32'd1);
        next();
        ctx_we_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'h1111_1111;
        #1;
        chk("cr_we", 32'(bus_we_o), 32'd0);
        chk("cr_be", 32'(bus_be_o), 32'hF);
        chk("cr_gnt", 32'(ctx_gnt_o), 32'd1);
        chk("cw_rsp_ctx_rvalid", 32'(ctx_rvalid_o), 32'd0);
        chk("cw_rsp_core_rvalid", 32'(core_rvalid_o), 32'd0);
        next();
        ctx_req_i = 0; bus_gnt_i = 0; bus_rdata_i = 32'hCAFE_F00D;
        #1;
        chk("cr_outstanding", 32'(outstanding_o), 32'd1);
        chk("cr_ctx_rvalid", 32'(ctx_rvalid_o), 32'd1);
        chk("cr_ctx_rdata", ctx_rdata_o, 32'hCAFE_F00D);
        chk("cr_core_rvalid", 32'(core_rvalid_o), 32'd0);
        next();
        bus_rvalid_i = 0;
        #1; chk("cr_outstanding0", 32'(outstanding_o), 32'd0);

        // Held request stays frozen on the bus even when core retracts
        next();
        core_req_i = 1; core_addr_i = 32'hA0; core_be_i = 4'h3;
        ctx_req_i = 1; ctx_addr_i = 32'hB0;
        #1; chk("hold0_addr", bus_addr_o, 32'hA0); chk("hold0_req", 32'(bus_req_o), 32'd1);
        next();
        #1; chk("hold1_addr", bus_addr_o, 32'hA0); chk("hold1_ctx_gnt", 32'(ctx_gnt_o), 32'd0);
        next();
        core_req_i = 0;
        #1;
        chk("hold2_addr", bus_addr_o, 32'hA0);
        chk("hold2_req", 32'(bus_req_o), 32'd0);
        chk("hold2_be", 32'(bus_be_o), 32'h3);
        next();
        core_req_i = 1; bus_gnt_i = 1;
        #1; chk("hold3_core_gnt", 32'(core_gnt_o), 32'd1); chk("hold3_ctx_gnt", 32'(ctx_gnt_o), 32'd0);
        next();
        core_req_i = 0;
        #1; chk("hold4_ctx_gnt", 32'(ctx_gnt_o), 32'd1); chk("hold4_addr", bus_addr_o, 32'hB0);
        next();
        ctx_req_i = 0; bus_gnt_i = 0; bus_rvalid_i = 1;
        #1; chk("hold_rsp_core", 32'(core_rvalid_o), 32'd1);
        next();
        #1; chk("hold_rsp_ctx", 32'(ctx_rvalid_o), 32'd1);
        next();
        bus_rvalid_i = 0;

        // Fill the tracker; full blocks even in the cycle of a pop
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            if (k != 0) next();
            core_req_i = 1; core_addr_i = 32'(k); bus_gnt_i = 1;
            #1; chk($sformatf("fill%0d_gnt", k), 32'(core_gnt_o), 32'd1);
        end
        next();
        #1;
        chk("full_outstanding", 32'(outstanding_o), 32'd4);
        chk("full_req", 32'(bus_req_o), 32'd0);
        chk("full_gnt", 32'(core_gnt_o), 32'd0);
        next();
        bus_rvalid_i = 1;
        #1; chk("full_pop_req", 32'(bus_req_o), 32'd0); chk("full_pop_rvalid", 32'(core_rvalid_o), 32'd1);
        next();
        bus_rvalid_i = 0;
        #1;
        chk("release_outstanding", 32'(outstanding_o), 32'd3);
        chk("release_req", 32'(bus_req_o), 32'd1);
        chk("release_gnt", 32'(core_gnt_o), 32'd1);
        next();
        core_req_i = 0; bus_gnt_i = 0;
        #1; chk("refill_outstanding", 32'(outstanding_o), 32'd4);
        for (int k = 0; k < 4; k++) begin
            next();
            bus_rvalid_i = 1;
            #1; chk($sformatf("drain%0d_rvalid", k), 32'(core_rvalid_o), 32'd1);
        end
        next();
        bus_rvalid_i = 0;
        #1; chk("drain_outstanding", 32'(outstanding_o), 32'd0);

        // Orphan response is sticky until reset
        next();
        bus_rvalid_i = 1;
        #1;
        chk("orph_core_rvalid", 32'(core_rvalid_o), 32'd0);
        chk("orph_ctx_rvalid", 32'(ctx_rvalid_o), 32'd0);
        chk("orph_before", 32'(orphan_rsp_o), 32'd0);
        next();
        bus_rvalid_i = 0;
        #1; chk("orph_set", 32'(orphan_rsp_o), 32'd1);
        next(); next();
        #1; chk("orph_sticky", 32'(orphan_rsp_o), 32'd1);
        reset_dut();
        #1; chk("orph_cleared", 32'(orphan_rsp_o), 32'd0);

`ifdef CTX_ARB_STARVE_GUARD_EN
        // Grant order core, core, ctx repeating under continuous contention
        begin
            bit exp_ctx [6];
            exp_ctx = '{0, 0, 1, 0, 0, 1};
            reset_dut();
            for (int k = 0; k < 6; k++) begin
                if (k != 0) next();
                core_req_i = 1; ctx_req_i = 1; bus_gnt_i = 1;
                bus_rvalid_i = (k != 0);
                #1;
                chk($sformatf("guard%0d_ctx_gnt", k), 32'(ctx_gnt_o), 32'(exp_ctx[k]));
                chk($sformatf("guard%0d_core_gnt", k), 32'(core_gnt_o), 32'(!exp_ctx[k]));
            end
            next();
            clear_inputs();
            bus_rvalid_i = 1;
            next();
            bus_rvalid_i = 0;
        end
`endif

        // Random traffic against the queue model
        reset_dut();
        q.delete(); lock = 0; burst = 0; orphan_m = 0;
        last_cgnt = 1; last_xgnt = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) next();
            if (!core_req_i || last_cgnt) begin
                core_req_i   = ($urandom_range(0, 99) < 55);
                core_we_i    = 1'($urandom);
                core_be_i    = 4'($urandom);
                core_addr_i  = $urandom;
                core_wdata_i = $urandom;
            end
            if (!ctx_req_i || last_xgnt) begin
                ctx_req_i   = ($urandom_range(0, 99) < 50);
                ctx_we_i    = 1'($urandom);
                ctx_addr_i  = $urandom;
                ctx_wdata_i = $urandom;
            end
            bus_gnt_i    = ($urandom_range(0, 99) < 65);
            bus_rvalid_i = (q.size() > 0) && ($urandom_range(0, 99) < 40);
            bus_rdata_i  = $urandom;
            #1;

            starve = guard_on && (burst >= int'(BURST));
            win = 0; req = 0;
            if (lock == 1) begin
                win = 1; req = core_req_i;
            end else if (lock == 2) begin
                win = 2; req = ctx_req_i;
            end else if (q.size() < int'(MAXO) && (core_req_i || ctx_req_i)) begin
                req = 1;
                win = (ctx_req_i && (starve || !core_req_i)) ? 2 : 1;
            end
            xfer = req && bus_gnt_i;
            pop  = bus_rvalid_i && (q.size() > 0);
            exp_addr = (win == 1) ? core_addr_i : (win == 2) ? ctx_addr_i : 32'h0;

            chk("rnd_bus_req", 32'(bus_req_o), 32'(req));
            chk("rnd_bus_addr", bus_addr_o, exp_addr);
            chk("rnd_core_gnt", 32'(core_gnt_o), 32'(xfer && win == 1));
            chk("rnd_ctx_gnt", 32'(ctx_gnt_o), 32'(xfer && win == 2));
            chk("rnd_core_rvalid", 32'(core_rvalid_o), 32'(pop && !q[0].ctx));
            chk("rnd_ctx_rvalid", 32'(ctx_rvalid_o), 32'(pop && q[0].ctx && !q[0].we));
            chk("rnd_outstanding", 32'(outstanding_o), 32'(q.size()));
            chk("rnd_orphan", 32'(orphan_rsp_o), 32'(orphan_m));

            if (bus_rvalid_i && q.size() == 0) orphan_m = 1;
            if (pop) void'(q.pop_front());
            if (xfer) q.push_back(ent_t'{ctx: (win == 2), we: (win == 2) ? ctx_we_i : core_we_i});
            lock = xfer ? 0 : (req ? win : lock);
            if (!ctx_req_i || (xfer && win == 2)) burst = 0;
            else if (xfer && win == 1 && burst < int'(BURST)) burst++;
            last_cgnt = xfer && win == 1;
            last_xgnt = xfer && win == 2;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
